serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one 1-bit full adder plus a carry flop
// computes a WIDTH-bit a + b + cin, LSB first, behind a start/done handshake.
// The result is held until the next operation completes.

// 1-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_next;
   logic             cy;
   logic             cy_msb;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_carry;

   // The only arithmetic on operand bits: LSBs of the shifters plus the carry flop
   full_adder fa (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .c     (cy),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New result bit enters at the MSB while the oldest bit falls off the LSB
   always_comb begin
      s_next = WIDTH'({fa_sum, s_sr} >> 1);
   end

   // Signed overflow: carry out of the MSB XOR the carry that went into it.
   // Both terms are flops written only on the final RUN edge or on reset.
   assign ovf = cout ^ cy_msb;

   // Sequencer: IDLE accepts operands, RUN does one bit per edge, DONE pulses done
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
         cy_msb <= 1'b0;
         cnt    <= '0;
         cy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  cy    <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               s_sr <= s_next;
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cy   <= fa_carry;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // Here cy is the carry into the MSB
                  cy_msb <= cy;
                  sum    <= s_next;
                  cout   <= fa_carry;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 hand vectors, handshake
// corner cases and reset, plus an exhaustive WIDTH=4 sweep.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       cin4 = 1'b0;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] sum4;

   int n_vec  = 0;
   int n_miss = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; drive and sample 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation on the 8-bit instance with hand-computed results
   task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [7:0] es, input logic ec, input logic eo);
      int lat;
      lat = 0;
      a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
      step();
      start8 = 1'b0;
      check({tag, "_busy_rise"}, 64'(busy8), 64'd1);
      for (int k = 1; k <= 20; k++) begin
         step();
         if (done8) begin
            lat = k;
            break;
         end
      end
      check({tag, "_done_edge"}, 64'(lat), 64'd8);
      check({tag, "_sum"}, 64'(sum8), 64'(es));
      check({tag, "_cout"}, 64'(cout8), 64'(ec));
      check({tag, "_ovf"}, 64'(ovf8), 64'(eo));
      step();
      check({tag, "_done_width"}, 64'(done8), 64'd0);
      check({tag, "_busy_fall"}, 64'(busy8), 64'd0);
   endtask

   initial begin
      int dones;
      // Reset state
      step();
      step();
      check("rst_busy", 64'(busy8), 64'd0);
      check("rst_done", 64'(done8), 64'd0);
      check("rst_sum", 64'(sum8), 64'd0);
      check("rst_cout", 64'(cout8), 64'd0);
      check("rst_ovf", 64'(ovf8), 64'd0);
      check("rst_busy4", 64'(busy4), 64'd0);
      rst_n = 1'b1;
      step();

      // Directed WIDTH=8 vectors
      run8("v3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
      run8("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run8("v7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run8("v8080", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run8("v0000c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      run8("vffffc", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // start pulses at E0+3 (RUN) and E0+9 (DONE) are ignored
      a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
      step();                       // E0
      start8 = 1'b0;
      step(); step();               // E0+2
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
      step();                       // E0+3
      start8 = 1'b0;
      dones = 0;
      for (int k = 4; k <= 7; k++) begin
         step();
         if (done8) dones++;
      end
      a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
      step();                       // E0+8
      check("ign_done", 64'(done8), 64'd1);
      check("ign_sum", 64'(sum8), 64'h46);
      check("ign_cout", 64'(cout8), 64'd0);
      step();                       // E0+9, start seen in DONE
      start8 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (done8) dones++;
      end
      check("ign_extra_done", 64'(dones), 64'd0);
      check("ign_idle", 64'(busy8), 64'd0);
      check("ign_sum_hold", 64'(sum8), 64'h46);

      // start held high: second accept at E0+10 with operands present then
      a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
      step();                       // E0
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b1;
      for (int k = 1; k <= 8; k++) step();
      check("hold_done1", 64'(done8), 64'd1);
      check("hold_sum1", 64'(sum8), 64'h03);
      step();                       // E0+9
      check("hold_busy_gap", 64'(busy8), 64'd0);
      step();                       // E0+10
      start8 = 1'b0;
      check("hold_accept", 64'(busy8), 64'd1);
      check("hold_sum_kept", 64'(sum8), 64'h03);
      for (int k = 11; k <= 18; k++) step();
      check("hold_done2", 64'(done8), 64'd1);
      check("hold_sum2", 64'(sum8), 64'h31);
      step();

      // Reset at E0+4 discards the operation
      a8 = 8'h5A; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
      step();                       // E0
      start8 = 1'b0;
      step(); step(); step();       // E0+3
      rst_n = 1'b0;
      start8 = 1'b1;
      step();                       // E0+4
      check("mid_rst_busy", 64'(busy8), 64'd0);
      check("mid_rst_done", 64'(done8), 64'd0);
      check("mid_rst_sum", 64'(sum8), 64'd0);
      check("mid_rst_cout", 64'(cout8), 64'd0);
      check("mid_rst_ovf", 64'(ovf8), 64'd0);
      step();
      check("rst_start_ign", 64'(busy8), 64'd0);
      start8 = 1'b0;
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         if (done8 || busy8) dones++;
      end
      check("post_rst_quiet", 64'(dones), 64'd0);
      run8("post_rst", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);

      // Exhaustive WIDTH=4 sweep against an integer signed/unsigned model
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               int busy_cnt, done_cnt, su, ss;
               logic [4:0] got;
               logic       got_ovf;
               got = '0; got_ovf = 1'b0;
               busy_cnt = 0; done_cnt = 0;
               a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0]; start4 = 1'b1;
               step();
               start4 = 1'b0;
               if (busy4) busy_cnt++;
               for (int k = 1; k <= 7; k++) begin
                  step();
                  if (busy4) busy_cnt++;
                  if (done4) begin
                     done_cnt++;
                     got = {cout4, sum4};
                     got_ovf = ovf4;
                  end
               end
               su = ia + ib + ic;
               ss = (ia > 7 ? ia - 16 : ia) + (ib > 7 ? ib - 16 : ib) + ic;
               check($sformatf("w4_sum_%0h_%0h_%0d", ia, ib, ic), 64'(got), 64'(su));
               check($sformatf("w4_ovf_%0h_%0h_%0d", ia, ib, ic), 64'(got_ovf),
                     64'((ss > 7 || ss < -8) ? 1 : 0));
               check($sformatf("w4_busy_%0h_%0h_%0d", ia, ib, ic), 64'(busy_cnt), 64'd5);
               check($sformatf("w4_done_%0h_%0h_%0d", ia, ib, ic), 64'(done_cnt), 64'd1);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
